// File: rtl/aibio_dll_lock_pkg.sv
// Shared types and defaults for the DLL lock controller.
package aibio_dll_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_MEAS   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } dll_st_e;

  typedef struct packed {
    logic done;
    logic bal;
    logic up;
  } win_rsp_t;

  localparam int DEF_CAP_W      = 5;
  localparam int DEF_CAP_INIT   = 16;
  localparam int DEF_THRESH_W   = 4;
  localparam int DEF_WIN_LEN    = 64;
  localparam int DEF_SETTLE_CYC = 16;
  localparam int DEF_LOCK_WINS  = 4;

  function automatic int cnt_width(input int win_len);
    return $clog2(win_len + 1);
  endfunction

endpackage

// File: rtl/aibio_dll_updn_window.sv
// Up/dn window counters with balance/direction decode; AIBIO_DLL_LOCK_DFX_EN exposes final counts.
module aibio_dll_updn_window
  import aibio_dll_lock_pkg::*;
#(
  parameter int WIN_LEN  = DEF_WIN_LEN,
  parameter int THRESH_W = DEF_THRESH_W,
  parameter int CNT_W    = cnt_width(WIN_LEN)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                active,
  input  logic                up,
  input  logic                dn,
  input  logic [THRESH_W-1:0] thresh,
  output win_rsp_t            rsp
`ifdef AIBIO_DLL_LOCK_DFX_EN
  ,
  output logic [CNT_W-1:0]    up_fin,
  output logic [CNT_W-1:0]    dn_fin
`endif
);

  localparam int CMP_W = (CNT_W > THRESH_W) ? CNT_W : THRESH_W;

  logic [CNT_W-1:0] up_cnt, dn_cnt, win_cnt;
  logic [CNT_W-1:0] up_tot, dn_tot, diff;

  // Decision includes the sample of the window's last cycle.
  always_comb begin
    up_tot   = up_cnt + CNT_W'(up);
    dn_tot   = dn_cnt + CNT_W'(dn);
    diff     = (up_tot >= dn_tot) ? (up_tot - dn_tot) : (dn_tot - up_tot);
    rsp      = '0;
    rsp.done = active && (win_cnt == CNT_W'(WIN_LEN - 1));
    rsp.bal  = CMP_W'(diff) <= CMP_W'(thresh);
    rsp.up   = up_tot > dn_tot;
  end

`ifdef AIBIO_DLL_LOCK_DFX_EN
  assign up_fin = up_tot;
  assign dn_fin = dn_tot;
`endif

  always_ff @(posedge clk) begin
    if (clr || !active || rsp.done) begin
      up_cnt  <= '0;
      dn_cnt  <= '0;
      win_cnt <= '0;
    end else begin
      up_cnt  <= up_tot;
      dn_cnt  <= dn_tot;
      win_cnt <= win_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aibio_dll_lock_ctrl.sv
// DLL calibration + lock detector; AIBIO_DLL_LOCK_DFX_EN adds last-window count/state outputs.
module aibio_dll_lock_ctrl
  import aibio_dll_lock_pkg::*;
#(
  parameter int CAP_W      = DEF_CAP_W,
  parameter int CAP_INIT   = DEF_CAP_INIT,
  parameter int THRESH_W   = DEF_THRESH_W,
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int LOCK_WINS  = DEF_LOCK_WINS
) (
  input  logic                i_clkin,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic                i_up,
  input  logic                i_dn,
  input  logic [THRESH_W-1:0] i_lockthresh,
  input  logic [1:0]          i_lockctrl,
  output logic [CAP_W-1:0]    o_capctrl,
  output logic                o_lock,
  output logic                o_fail,
  output logic                o_busy
`ifdef AIBIO_DLL_LOCK_DFX_EN
  ,
  output logic [cnt_width(WIN_LEN)-1:0] o_dfx_upcnt,
  output logic [cnt_width(WIN_LEN)-1:0] o_dfx_dncnt,
  output logic [2:0]                    o_dfx_state
`endif
);

  localparam int CNT_W = cnt_width(WIN_LEN);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int BAL_W = $clog2(LOCK_WINS + 1);
  localparam logic [CAP_W-1:0] CAP_RST = CAP_W'(CAP_INIT);

  dll_st_e          state;
  win_rsp_t         win;
  logic [SET_W-1:0] settle_cnt;
  logic [BAL_W-1:0] bal_cnt;
  logic [1:0]       bad_cnt;
  logic             clr, active, sat;
  logic [CAP_W-1:0] cap_nxt;

  assign clr    = i_reset || !i_en;
  assign active = (state == ST_MEAS) || (state == ST_LOCKED);

  // Stepping past either end of the code range is a calibration failure, never a wrap.
  always_comb begin
    sat     = win.up ? (o_capctrl == '1) : (o_capctrl == '0);
    cap_nxt = win.up ? (o_capctrl + 1'b1) : (o_capctrl - 1'b1);
  end

`ifdef AIBIO_DLL_LOCK_DFX_EN
  logic [CNT_W-1:0] up_fin, dn_fin;
`endif

  aibio_dll_updn_window #(
    .WIN_LEN  (WIN_LEN),
    .THRESH_W (THRESH_W),
    .CNT_W    (CNT_W)
  ) u_win (
    .clk    (i_clkin),
    .clr    (clr),
    .active (active),
    .up     (i_up),
    .dn     (i_dn),
    .thresh (i_lockthresh),
    .rsp    (win)
`ifdef AIBIO_DLL_LOCK_DFX_EN
    ,
    .up_fin (up_fin),
    .dn_fin (dn_fin)
`endif
  );

  always_ff @(posedge i_clkin) begin
    if (clr) begin
      state      <= ST_IDLE;
      o_capctrl  <= CAP_RST;
      o_lock     <= 1'b0;
      o_fail     <= 1'b0;
      o_busy     <= 1'b0;
      settle_cnt <= '0;
      bal_cnt    <= '0;
      bad_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_SETTLE;
          o_busy     <= 1'b1;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
            state      <= ST_MEAS;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_MEAS: begin
          if (win.done) begin
            if (win.bal) begin
              if (bal_cnt == BAL_W'(LOCK_WINS - 1)) begin
                state   <= ST_LOCKED;
                o_lock  <= 1'b1;
                o_busy  <= 1'b0;
                bal_cnt <= '0;
                bad_cnt <= '0;
              end else begin
                bal_cnt <= bal_cnt + 1'b1;
              end
            end else begin
              bal_cnt <= '0;
              if (sat) begin
                state  <= ST_FAIL;
                o_fail <= 1'b1;
                o_busy <= 1'b0;
              end else begin
                state     <= ST_SETTLE;
                o_capctrl <= cap_nxt;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (win.done) begin
            if (win.bal) begin
              bad_cnt <= '0;
            end else if (bad_cnt >= i_lockctrl) begin
              // Hysteresis exhausted: drop lock and recalibrate.
              o_lock  <= 1'b0;
              bad_cnt <= '0;
              bal_cnt <= '0;
              if (sat) begin
                state  <= ST_FAIL;
                o_fail <= 1'b1;
              end else begin
                state      <= ST_SETTLE;
                o_capctrl  <= cap_nxt;
                o_busy     <= 1'b1;
                settle_cnt <= '0;
              end
            end else begin
              bad_cnt <= bad_cnt + 1'b1;
            end
          end
        end
        ST_FAIL: begin
          o_fail <= 1'b1;
          o_lock <= 1'b0;
          o_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AIBIO_DLL_LOCK_DFX_EN
  // Snapshot of the last completed window and the state that owned it.
  always_ff @(posedge i_clkin) begin
    if (clr) begin
      o_dfx_upcnt <= '0;
      o_dfx_dncnt <= '0;
      o_dfx_state <= '0;
    end else if (win.done) begin
      o_dfx_upcnt <= up_fin;
      o_dfx_dncnt <= dn_fin;
      o_dfx_state <= state;
    end
  end
`endif

endmodule

// File: tb/tb_aibio_dll_lock_ctrl.sv
// Directed bench for aibio_dll_lock_ctrl (default parameters); DFX ports checked when AIBIO_DLL_LOCK_DFX_EN is set.
module tb_aibio_dll_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, up, dn;
  logic [3:0] thresh;
  logic [1:0] lockctrl;
  logic [4:0] cap;
  logic       lock, fail, busy;
`ifdef AIBIO_DLL_LOCK_DFX_EN
  logic [6:0] dfx_up, dfx_dn;
  logic [2:0] dfx_st;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nup = 0;
  int ndn = 0;

  always #5 clk = ~clk;

  aibio_dll_lock_ctrl dut (
    .i_clkin      (clk),
    .i_reset      (rst),
    .i_en         (en),
    .i_up         (up),
    .i_dn         (dn),
    .i_lockthresh (thresh),
    .i_lockctrl   (lockctrl),
    .o_capctrl    (cap),
    .o_lock       (lock),
    .o_fail       (fail),
    .o_busy       (busy)
`ifdef AIBIO_DLL_LOCK_DFX_EN
    ,
    .o_dfx_upcnt  (dfx_up),
    .o_dfx_dncnt  (dfx_dn),
    .o_dfx_state  (dfx_st)
`endif
  );

  // Periodic PD pattern: any 64 consecutive cycles hold exactly nup ups and ndn dns.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      up = (cyc % 64) < nup;
      dn = (cyc % 64) < ndn;
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    run(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    thresh = 4'd2; lockctrl = 2'd1; nup = 0; ndn = 0;
    rst = 1'b1; en = 1'b1;
    run(2);
    checks++; if (cap !== 5'd16) begin failures++; $display("FAIL reset_cap got=%0d exp=16", cap); end
    checks++; if ({lock, fail, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {lock, fail, busy}); end
    rst = 1'b0;
  endtask

  task automatic test_lock_alt();
    do_reset();
    thresh = 4'd2; nup = 32; ndn = 32; en = 1'b1;
    run(1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL alt_busy got=%b exp=1", busy); end
    run(271);
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL alt_lock_early got=%b exp=0", lock); end
    run(1);
    checks++; if ({lock, busy, cap} !== {1'b1, 1'b0, 5'd16}) begin failures++; $display("FAIL alt_lock got=%b/%b/%0d exp=1/0/16", lock, busy, cap); end
  endtask

  task automatic test_up_saturate();
    do_reset();
    nup = 64; ndn = 0; en = 1'b1;
    run(81);
    checks++; if (cap !== 5'd17) begin failures++; $display("FAIL sat_first_step got=%0d exp=17", cap); end
    run(1120);
    checks++; if ({cap, fail, busy} !== {5'd31, 1'b0, 1'b1}) begin failures++; $display("FAIL sat_top got=%0d/%b/%b exp=31/0/1", cap, fail, busy); end
    run(80);
    checks++; if ({cap, fail, lock, busy} !== {5'd31, 1'b1, 1'b0, 1'b0}) begin failures++; $display("FAIL sat_fail got=%0d/%b/%b/%b exp=31/1/0/0", cap, fail, lock, busy); end
    run(100);
    checks++; if ({cap, fail} !== {5'd31, 1'b1}) begin failures++; $display("FAIL sat_hold got=%0d/%b exp=31/1", cap, fail); end
    en = 1'b0;
    run(1);
    checks++; if ({cap, fail} !== {5'd16, 1'b0}) begin failures++; $display("FAIL fail_exit got=%0d/%b exp=16/0", cap, fail); end
  endtask

  task automatic test_dn_then_bal();
    do_reset();
    thresh = 4'd2; nup = 0; ndn = 64; en = 1'b1;
    run(241);
    checks++; if (cap !== 5'd13) begin failures++; $display("FAIL dn_code got=%0d exp=13", cap); end
    nup = 32; ndn = 32;
    run(271);
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL dn_lock_early got=%b exp=0", lock); end
    run(1);
    checks++; if ({lock, cap} !== {1'b1, 5'd13}) begin failures++; $display("FAIL dn_lock got=%b/%0d exp=1/13", lock, cap); end
  endtask

  // Continues from the locked state left by test_dn_then_bal (code 13).
  task automatic test_hysteresis();
    lockctrl = 2'd1;
    nup = 64; ndn = 0;
    run(64);
    checks++; if ({lock, cap} !== {1'b1, 5'd13}) begin failures++; $display("FAIL hyst_one_bad got=%b/%0d exp=1/13", lock, cap); end
    nup = 32; ndn = 32;
    run(64);
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL hyst_good got=%b exp=1", lock); end
    nup = 64; ndn = 0;
    run(64);
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL hyst_bad1 got=%b exp=1", lock); end
    run(64);
    checks++; if ({lock, cap, busy} !== {1'b0, 5'd14, 1'b1}) begin failures++; $display("FAIL hyst_drop got=%b/%0d/%b exp=0/14/1", lock, cap, busy); end
    nup = 32; ndn = 32;
    run(272);
    checks++; if ({lock, cap} !== {1'b1, 5'd14}) begin failures++; $display("FAIL relock got=%b/%0d exp=1/14", lock, cap); end
    en = 1'b0;
    run(1);
    checks++; if ({cap, lock, busy} !== {5'd16, 1'b0, 1'b0}) begin failures++; $display("FAIL en_drop got=%0d/%b/%b exp=16/0/0", cap, lock, busy); end
  endtask

  task automatic test_reset_mid();
    nup = 0; ndn = 64; en = 1'b1;
    run(81);
    nup = 32; ndn = 32;
    run(36);
    checks++; if ({cap, busy} !== {5'd15, 1'b1}) begin failures++; $display("FAIL mid_meas got=%0d/%b exp=15/1", cap, busy); end
    rst = 1'b1;
    run(1);
    checks++; if ({cap, lock, busy, fail} !== {5'd16, 3'b000}) begin failures++; $display("FAIL mid_reset got=%0d/%b%b%b exp=16/000", cap, lock, busy, fail); end
    rst = 1'b0;
  endtask

  task automatic test_thresh_edge();
    do_reset();
    thresh = 4'd2; nup = 31; ndn = 34; en = 1'b1;
    run(81);
    checks++; if (cap !== 5'd15) begin failures++; $display("FAIL thr_diff3 got=%0d exp=15", cap); end
    nup = 33; ndn = 31;
    run(272);
    checks++; if ({lock, cap} !== {1'b1, 5'd15}) begin failures++; $display("FAIL thr_diff2 got=%b/%0d exp=1/15", lock, cap); end
  endtask

  task automatic test_both_high();
    do_reset();
    thresh = 4'd0; nup = 64; ndn = 64; en = 1'b1;
    run(272);
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL both_early got=%b exp=0", lock); end
`ifdef AIBIO_DLL_LOCK_DFX_EN
    checks++; if ({dfx_up, dfx_dn} !== {7'd64, 7'd64}) begin failures++; $display("FAIL dfx_cnt got=%0d/%0d exp=64/64", dfx_up, dfx_dn); end
`endif
    run(1);
    checks++; if ({lock, cap} !== {1'b1, 5'd16}) begin failures++; $display("FAIL both_lock got=%b/%0d exp=1/16", lock, cap); end
`ifdef AIBIO_DLL_LOCK_DFX_EN
    checks++; if ({dfx_up, dfx_dn, dfx_st} !== {7'd64, 7'd64, 3'd2}) begin failures++; $display("FAIL dfx_last got=%0d/%0d/%0d exp=64/64/2", dfx_up, dfx_dn, dfx_st); end
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0; thresh = 4'd2; lockctrl = 2'd1;
    test_reset();
    test_lock_alt();
    test_up_saturate();
    test_dn_then_bal();
    test_hysteresis();
    test_reset_mid();
    test_thresh_edge();
    test_both_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
